// File: rtl/random_roller_pkg.sv
// Shared types and constants for the random_roller game core.
package random_roller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting Fibonacci register
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/random_roller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reset reloads the seed.
module lfsr16
  import random_roller_pkg::*;
#(
  parameter logic [15:0] SEED  = DEFAULT_SEED,
  parameter int          OUT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [OUT_W-1:0] o_value
);

  logic [15:0] lfsr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lfsr_q <= SEED;
    else       lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign o_value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/random_roller.sv
// Game core: samples the LFSR on a slowing schedule, commits results to a
// history ring and replays older results while show is held.
module random_roller
  import random_roller_pkg::*;
#(
  parameter int          WIDTH            = 4,
  parameter int          HIST_DEPTH       = 4,
  parameter int          BASE_PERIOD      = 4,
  parameter int          STEPS            = 6,
  parameter int          UPDATES_PER_STEP = 4,
  parameter logic [15:0] SEED             = DEFAULT_SEED
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic                            i_stop,
  input  logic                            i_show,
  output logic [WIDTH-1:0]                o_random_out,
  output logic                            o_busy,
  output logic [$clog2(HIST_DEPTH+1)-1:0] o_hist_count,
  output logic [$clog2(HIST_DEPTH)-1:0]   o_hist_idx
);

  localparam int CW     = $clog2(HIST_DEPTH + 1);
  localparam int IW     = $clog2(HIST_DEPTH);
  localparam int PW_RAW = $clog2(BASE_PERIOD << (STEPS - 1));
  localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
  localparam int SW     = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int UW     = (UPDATES_PER_STEP > 1) ? $clog2(UPDATES_PER_STEP) : 1;

  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);
  localparam logic [UW-1:0] UPD_LAST  = UW'(UPDATES_PER_STEP - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] lfsr_w;
  logic             start_p0, start_p1, stop_p0, stop_p1, show_p0, show_p1;
  logic             start_rise, stop_rise, show_rise, show_fall;
  logic [PW-1:0]    cyc, pm1;
  logic [SW-1:0]    step;
  logic [UW-1:0]    upd;
  logic             tick, last, upd_now;
  logic             load, commit, show_enter, show_exit;
  logic [WIDTH-1:0] disp, disp_nx;
  logic [WIDTH-1:0] hist [HIST_DEPTH];
  logic [IW-1:0]    wr_ptr, sel, sel_next, rd_idx, newest_idx;
  logic [CW-1:0]    count, sel_inc;

  // Steps back through the ring from ptr; back never exceeds HIST_DEPTH.
  function automatic logic [IW-1:0] ring_back(input logic [IW-1:0] ptr,
                                              input logic [IW:0]   back);
    logic [IW+1:0] p;
    logic [IW+1:0] b;
    p = (IW+2)'(ptr);
    b = (IW+2)'(back);
    if (p >= b) ring_back = IW'(p - b);
    else        ring_back = IW'(p + (IW+2)'(HIST_DEPTH) - b);
  endfunction

  lfsr16 #(.SEED(SEED), .OUT_W(WIDTH)) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_value(lfsr_w)
  );

  // Stage p0 samples the pins, p1 holds the previous sample for edge detect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      start_p0 <= 1'b0; start_p1 <= 1'b0;
      stop_p0  <= 1'b0; stop_p1  <= 1'b0;
      show_p0  <= 1'b0; show_p1  <= 1'b0;
    end else begin
      start_p0 <= i_start; start_p1 <= start_p0;
      stop_p0  <= i_stop;  stop_p1  <= stop_p0;
      show_p0  <= i_show;  show_p1  <= show_p0;
    end
  end

  assign start_rise = start_p0 & ~start_p1;
  assign stop_rise  = stop_p0  & ~stop_p1;
  assign show_rise  = show_p0  & ~show_p1;
  assign show_fall  = ~show_p0 & show_p1;

  // pm1 holds period-1 so the longest period still fits the counter width
  assign tick    = (cyc == pm1);
  assign last    = tick && (upd == UPD_LAST) && (step == STEP_LAST);
  assign upd_now = (state == ROLL) && !stop_rise && !start_rise && tick;
  assign disp_nx = upd_now ? lfsr_w : disp;

  assign sel_inc    = CW'(sel) + CW'(1);
  assign sel_next   = (sel_inc >= count) ? '0 : IW'(sel_inc);
  assign newest_idx = ring_back(wr_ptr, (IW+1)'(1));
  assign rd_idx     = ring_back(wr_ptr, (IW+1)'(sel) + (IW+1)'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load       = 1'b0;
    commit     = 1'b0;
    show_enter = 1'b0;
    show_exit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_rise) begin
          state_nx = ROLL;
          load     = 1'b1;
        end else if (show_rise && count != '0) begin
          state_nx   = SHOW;
          show_enter = 1'b1;
        end
      end
      ROLL: begin
        if (stop_rise) begin
          state_nx = IDLE;
          commit   = 1'b1;
        end else if (start_rise) begin
          load = 1'b1;
        end else if (last) begin
          state_nx = IDLE;
          commit   = 1'b1;
        end
      end
      SHOW: begin
        if (start_rise) begin
          state_nx = ROLL;
          load     = 1'b1;
        end else if (show_fall) begin
          state_nx  = IDLE;
          show_exit = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (state == ROLL);
    o_hist_idx   = '0;
    o_random_out = disp;
    if (state == SHOW) begin
      o_hist_idx   = sel;
      o_random_out = hist[rd_idx];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cyc  <= '0;
      pm1  <= '0;
      step <= '0;
      upd  <= '0;
    end else if (load) begin
      cyc  <= '0;
      pm1  <= PW'(BASE_PERIOD - 1);
      step <= '0;
      upd  <= '0;
    end else if (state == ROLL && !stop_rise) begin
      if (tick) begin
        cyc <= '0;
        if (upd == UPD_LAST) begin
          upd  <= '0;
          step <= step + 1'b1;
          pm1  <= (pm1 << 1) | PW'(1);
        end else begin
          upd <= upd + 1'b1;
        end
      end else begin
        cyc <= cyc + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      disp   <= '0;
      wr_ptr <= '0;
      sel    <= '0;
      count  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
    end else begin
      disp <= disp_nx;
      if (show_exit) disp <= hist[newest_idx];
      if (commit) begin
        hist[wr_ptr] <= disp_nx;
        wr_ptr       <= (wr_ptr == IW'(HIST_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (count != CW'(HIST_DEPTH)) count <= count + 1'b1;
        sel <= '0;
      end
      if (show_enter) sel <= sel_next;
    end
  end

  assign o_hist_count = count;

endmodule

// File: tb/tb_random_roller.sv
// Randomised-timing bench for random_roller against a schedule/queue model.
module tb_random_roller;

  localparam int          WIDTH            = 4;
  localparam int          HIST_DEPTH       = 4;
  localparam int          BASE_PERIOD      = 4;
  localparam int          STEPS            = 6;
  localparam int          UPDATES_PER_STEP = 4;
  localparam logic [15:0] SEED             = 16'hACE1;
  localparam int          SEQ_N            = 16384;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             show = 1'b0;
  logic [WIDTH-1:0] random_out;
  logic             busy;
  logic [2:0]       hist_count;
  logic [1:0]       hist_idx;

  random_roller #(
    .WIDTH(WIDTH), .HIST_DEPTH(HIST_DEPTH), .BASE_PERIOD(BASE_PERIOD),
    .STEPS(STEPS), .UPDATES_PER_STEP(UPDATES_PER_STEP), .SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_show(show),
    .o_random_out(random_out), .o_busy(busy),
    .o_hist_count(hist_count), .o_hist_idx(hist_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Model LFSR timeline: seq[k] is the register value after k clock edges.
  logic [15:0] m_lfsr;
  int          ecount;
  logic [15:0] seq [SEQ_N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= SEED;
      ecount <= 0;
      seq[0] <= SEED;
    end else begin
      m_lfsr                      <= lfsr_next(m_lfsr);
      ecount                      <= ecount + 1;
      seq[(ecount + 1) % SEQ_N]   <= lfsr_next(m_lfsr);
    end
  end

  int               cum[$];
  logic [WIDTH-1:0] m_hist[$];
  logic [WIDTH-1:0] m_disp;
  int               m_sel;

  function automatic int upd_count(input int el);
    int n = 0;
    foreach (cum[i]) if (cum[i] <= el) n++;
    return n;
  endfunction

  task automatic do_run(input int stop_at, input bit with_start);
    int               e0, end_el, k, lim, busy_len;
    logic [WIDTH-1:0] base_disp, exp_disp;
    base_disp = m_disp;
    exp_disp  = m_disp;
    busy_len  = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    chk("busy_pre", busy, 1'b0);
    e0     = ecount + 1;
    end_el = (stop_at < 0) ? cum[cum.size()-1] : stop_at + 2;
    @(negedge clk); start = 1'b0;
    chk("idx_roll", hist_idx, 0);
    for (int el = 0; el <= end_el; el++) begin
      if (el > 0) @(negedge clk);
      lim      = (stop_at >= 0 && el > end_el - 1) ? end_el - 1 : el;
      k        = upd_count(lim);
      exp_disp = (k == 0) ? base_disp : seq[(e0 + cum[k-1] - 1) % SEQ_N][WIDTH-1:0];
      chk("disp", random_out, exp_disp);
      chk("busy", busy, el < end_el);
      if (busy) busy_len++;
      if (stop_at >= 0 && el == stop_at) begin
        stop = 1'b1;
        if (with_start) start = 1'b1;
      end
    end
    chk("busy_len", busy_len, (stop_at < 0) ? 1008 : stop_at + 2);
    m_disp = exp_disp;
    m_hist.push_back(exp_disp);
    if (m_hist.size() > HIST_DEPTH) void'(m_hist.pop_front());
    m_sel = 0;
    chk("hist_count", hist_count, m_hist.size());
    stop  = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic show_press(input int hold);
    @(negedge clk); show = 1'b1;
    m_sel = (m_sel + 1) % m_hist.size();
    @(negedge clk);
    chk("idx_lat", hist_idx, 0);
    @(negedge clk);
    chk("show_idx", hist_idx, m_sel);
    chk("show_val", random_out, m_hist[m_hist.size()-1-m_sel]);
    repeat (hold) @(negedge clk);
    chk("show_hold", random_out, m_hist[m_hist.size()-1-m_sel]);
    chk("show_busy", busy, 1'b0);
    show = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rel_idx", hist_idx, 0);
    chk("rel_val", random_out, m_hist[m_hist.size()-1]);
  endtask

  initial begin
    for (int s = 0; s < STEPS; s++)
      for (int u = 0; u < UPDATES_PER_STEP; u++)
        cum.push_back((cum.size() == 0 ? 0 : cum[cum.size()-1]) + (BASE_PERIOD << s));
    m_disp = '0;
    m_sel  = 0;

    repeat (3) @(negedge clk);
    chk("rst_out", random_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", hist_count, 0);
    chk("rst_idx", hist_idx, 0);
    rst = 1'b0;
    chk("lfsr_seed", dut.u_lfsr.lfsr_q, SEED);
    @(negedge clk);
    chk("lfsr_step", dut.u_lfsr.lfsr_q, seq[ecount]);
    repeat ($urandom_range(1, 20)) @(negedge clk);

    do_run(-1, 1'b0);                       // A: full automatic schedule
    repeat ($urandom_range(1, 9)) @(negedge clk);
    do_run(491, 1'b0);                      // B: stopped early
    show_press(48);                         // age 1 = A, release shows B
    show_press(10);                         // wraps to age 0 = B

    do_run($urandom_range(100, 400), 1'b1); // start and stop rise together
    do_run($urandom_range(10, 90), 1'b0);
    do_run(-1, 1'b0);                       // fifth result evicts the first
    chk("full_count", hist_count, HIST_DEPTH);
    for (int p = 0; p < HIST_DEPTH; p++) show_press($urandom_range(2, 12));

    // Start pressed while history is on screen
    @(negedge clk); show = 1'b1;
    m_sel = (m_sel + 1) % m_hist.size();
    repeat (3) @(negedge clk);
    chk("show_pre_start", hist_idx, m_sel);
    do_run($urandom_range(30, 150), 1'b0);
    show = 1'b0;
    repeat (2) @(negedge clk);
    chk("after_show_idx", hist_idx, 0);
    chk("after_show_val", random_out, m_hist[m_hist.size()-1]);

    // Reset in the middle of a run
    @(negedge clk); start = 1'b1;
    repeat ($urandom_range(20, 200)) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", random_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", hist_count, 0);
    chk("mid_rst_idx", hist_idx, 0);
    chk("mid_rst_lfsr", dut.u_lfsr.lfsr_q, SEED);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_hist.delete();
    m_disp = '0;
    m_sel  = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    do_run($urandom_range(5, 60), 1'b0);
    show_press(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/random_roller.md
# random_roller

Parametrised successor to the Lab1 random-number top. A free-running 16-bit LFSR is sampled onto a WIDTH-bit display whose update rate slows in doubling steps after `i_start`. A run ends on `i_stop` or automatically when the schedule runs out, and the result is committed into a HIST_DEPTH-deep history ring. While `i_show` is held, an older result is displayed instead. It is the top-level game core; the display decoder consumes `o_random_out`.

## Interface
Parameters:
- WIDTH, 4, output width; legal range 1..16; `o_random_out` = lfsr[WIDTH-1:0].
- HIST_DEPTH, 4, number of committed results kept; must be ≥2.
- BASE_PERIOD, 4, cycles between display updates in step 0; must be ≥1.
- STEPS, 6, number of slowdown steps; the period doubles at each step.
- UPDATES_PER_STEP, 4, display updates per step.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- i_clk  in  1  clock; single clock domain. Reset is asynchronous and active-high.
- i_rst  in  1  asynchronous reset.
- i_start  in  1  level input; rising edge starts or restarts a run.
- i_stop  in  1  level input; rising edge ends a run early.
- i_show  in  1  level input; held high = show history.
- o_random_out  out  WIDTH  displayed value.
- o_busy  out  1  high while in ROLL.
- o_hist_count  out  $clog2(HIST_DEPTH+1)  number of valid history entries.
- o_hist_idx  out  $clog2(HIST_DEPTH)  age of the displayed entry (0 = newest).

## Operation
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. It steps every cycle in every state, so the sampled value depends on user timing.
- Edge detect: each of start, stop and show is registered. rise = in & ~prev; fall = ~in & prev.
- States are IDLE, ROLL and SHOW.
- IDLE:
  - start rise: go to ROLL. Load period = BASE_PERIOD, step = 0, upd = 0, cyc = 0.
  - show rise with count ≥1: go to SHOW with sel = (sel+1) mod count.
- ROLL:
  - cyc counts 0..period-1.
  - At terminal: o_random_out ← lfsr[WIDTH-1:0], then upd++.
  - When upd reaches UPDATES_PER_STEP-1: upd ← 0, step++, period ← period<<1.
  - After the last update of step STEPS-1: commit.
- Commit:
  - hist[wr_ptr] ← o_random_out; wr_ptr ← wr_ptr+1, wrapping at HIST_DEPTH.
  - count saturates at HIST_DEPTH; once full, the oldest entry is overwritten.
  - sel ← 0; go to IDLE.
- ROLL, stop rise: commit immediately. The displayed value freezes and is the committed value.
- ROLL, start rise without stop rise: restart the schedule; the display keeps its current value.
- ROLL, show: ignored.
- SHOW:
  - o_random_out = hist[(wr_ptr-1-sel) mod HIST_DEPTH]; o_hist_idx = sel.
  - show fall: go to IDLE and display the newest entry. sel is retained, so the next press shows the next older entry.
  - start rise: go to ROLL as from IDLE.
- Priority, same cycle: stop > start > show. In IDLE, a stop rise is ignored.
- Reset clears the history. Back-to-back runs need no reset.
- Outside SHOW, o_hist_idx = 0.

## Timing
- Reset values:
  - state IDLE; o_random_out = 0; o_busy = 0; o_hist_count = 0; o_hist_idx = 0.
  - lfsr = SEED; wr_ptr = sel = 0; all edge registers 0.
  - History entries are 0.
- Reset asserted mid-run aborts the run with no commit.
- Input rise sampled at edge n → state change visible after edge n+1 (one-cycle edge-detect latency).
- First display update: BASE_PERIOD cycles after ROLL is entered.
- Full auto run: UPDATES_PER_STEP·BASE_PERIOD·(2^STEPS−1) cycles. With defaults this is 1008 cycles and 24 updates; o_busy falls on the cycle after the last update.
- Stop rise at edge n: o_busy low and o_hist_count updated after edge n+1; o_random_out unchanged.
- Period counter width: $clog2(BASE_PERIOD<<(STEPS-1)). step and upd counters are sized for STEPS and UPDATES_PER_STEP.

## Structure
- Package random_roller_pkg holds:
  - state enum {IDLE, ROLL, SHOW};
  - LFSR tap constant;
  - default SEED.
- Sub-module lfsr16: free-running, with reset-to-seed input.
- History ring, counters and FSM live in random_roller. The ring is a flop array, not RAM.

## Test plan
- Reset → o_random_out = 0, o_busy = 0, o_hist_count = 0. LFSR state equals 16'hACE1 on release.
- Start held 2 cycles, no stop, defaults → exactly 24 updates:
  - intervals 4 (×4), 8 (×4), 16, 32, 64, 128 (×4 each);
  - o_busy falls after 1008 cycles; o_hist_count = 1.
- Start, then stop after 491 cycles → o_random_out frozen at the last update; hist entry 0 equals it; o_busy low one cycle after the stop rise.
- Two runs (results A, B), then show held 50 cycles → displays A with o_hist_idx = 1. Release → B. Second press → B with idx 0 (wrap, count = 2).
- Five runs with HIST_DEPTH = 4 → o_hist_count = 4 and the first result is lost. Successive show presses give ages 1, 2, 3, 0.
- Edge cases:
  - simultaneous start+stop rise in ROLL → commit, IDLE;
  - start rise during SHOW → ROLL, o_hist_idx = 0;
  - i_rst pulse mid-ROLL → all reset values, o_hist_count = 0.
